// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA256 block sequencer: round constants,
// initial hash value, word/hash types and the sequencer state encoding.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:7] hash_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WAIT = 3'd3,
        ADD  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_block_ctrl_if.sv
// Message-word stream into the sequencer and digest stream out of it.
// master = padder/consumer side, slave = sequencer side.
interface sha256_block_ctrl_if;
    import sha256_pkg::*;

    logic  msg_valid;
    logic  msg_ready;
    word_t msg_data;
    logic  msg_last;
    logic  dig_valid;
    logic  dig_ready;
    hash_t dig_data;

    modport master (
        output msg_valid, msg_data, msg_last, dig_ready,
        input  msg_ready, dig_valid, dig_data
    );

    modport slave (
        input  msg_valid, msg_data, msg_last, dig_ready,
        output msg_ready, dig_valid, dig_data
    );

endinterface

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, K[idx].
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0] idx,
    output word_t      k
);

    assign k = K[idx];

endmodule

// File: rtl/sha256_block_ctrl.sv
// Buffers one 16-word block, sequences 64 rounds of an external SHA256 core,
// folds the core result into the chaining value and emits the digest.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter logic [3:0]  CORE     = 4'b0,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    sha256_block_ctrl_if.slave stream,
    output logic               core_en,
    output logic [5:0]         core_rcntr,
    output word_t              core_kt,
    output word_t              core_mt,
    output hash_t              core_iv,
    input  hash_t              core_wreg,
    input  logic               core_valid,
    output logic [3:0]         core_id,
    output logic               busy,
    output logic               err
);

    localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t         state;
    state_t         nstate;
    logic [3:0]     wcnt;
    logic [5:0]     rnd;
    logic [WCW-1:0] wait_cnt;
    logic           wait_done;
    logic           accept;
    logic           last_q;
    logic           err_q;
    logic           msg_ready;
    logic           dig_valid;
    logic [5:0]     rom_idx;
    word_t          rom_k;
    word_t          msg_buf [0:15];
    hash_t          h_q;
    hash_t          wreg_q;

    assign accept    = (state == LOAD) && stream.msg_valid;
    assign wait_done = (wait_cnt == WCW'(WAIT_MAX - 1));
    // WAIT keeps presenting round 63 to the core
    assign rom_idx   = (state == WAIT) ? 6'd63 : rnd;

    sha256_k_rom u_k_rom (
        .idx (rom_idx),
        .k   (rom_k)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate     = state;
        msg_ready  = 1'b0;
        dig_valid  = 1'b0;
        core_en    = 1'b0;
        core_rcntr = '0;
        core_kt    = '0;
        core_mt    = '0;
        case (state)
            IDLE: nstate = LOAD;
            LOAD: begin
                msg_ready = 1'b1;
                if (stream.msg_valid && (wcnt == 4'd15)) nstate = RUN;
            end
            RUN: begin
                core_en    = 1'b1;
                core_rcntr = rnd;
                core_kt    = rom_k;
                if (rnd < 6'd16) core_mt = msg_buf[rnd[3:0]];
                if (rnd == 6'd63) nstate = WAIT;
            end
            WAIT: begin
                core_en    = 1'b1;
                core_rcntr = 6'd63;
                core_kt    = rom_k;
                if (core_valid) nstate = ADD;
                else if (wait_done) nstate = IDLE;
            end
            ADD:  nstate = last_q ? DONE : LOAD;
            DONE: begin
                dig_valid = 1'b1;
                if (stream.dig_ready) nstate = LOAD;
            end
            default: nstate = IDLE;
        endcase
    end

    // Control counters, sticky error and chaining value
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt     <= '0;
            rnd      <= '0;
            wait_cnt <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            h_q      <= H0;
        end else begin
            case (state)
                IDLE: h_q <= H0;
                LOAD: begin
                    rnd <= '0;
                    if (accept) begin
                        wcnt <= wcnt + 4'd1;
                        if (wcnt == 4'd15) last_q <= stream.msg_last;
                    end
                end
                RUN: begin
                    rnd      <= rnd + 6'd1;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (!core_valid) begin
                        if (wait_done) begin
                            err_q <= 1'b1;
                            h_q   <= H0;
                        end else begin
                            wait_cnt <= wait_cnt + WCW'(1);
                        end
                    end
                end
                ADD: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wreg_q[i];
                end
                DONE: if (stream.dig_ready) h_q <= H0;
                default: ;
            endcase
        end
    end

    // Data storage carries no reset; it is always written before it is read
    always_ff @(posedge clk) begin
        if (accept) msg_buf[wcnt] <= stream.msg_data;
        if ((state == WAIT) && core_valid) wreg_q <= core_wreg;
    end

    assign stream.msg_ready = msg_ready;
    assign stream.dig_valid = dig_valid;
    assign stream.dig_data  = h_q;
    assign core_iv          = h_q;
    assign core_id          = CORE;
    assign busy             = (state != IDLE);
    assign err              = err_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Bench for sha256_block_ctrl: a behavioural SHA256 round core closes the loop
// and known-answer digests are compared against hand-computed values.
module tb_sha256_block_ctrl;
    import sha256_pkg::*;

    localparam logic [255:0] H0_EXP    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_en;
    logic [5:0] core_rcntr;
    word_t      core_kt;
    word_t      core_mt;
    hash_t      core_iv;
    hash_t      core_wreg;
    logic       core_valid;
    logic [3:0] core_id;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    sha256_block_ctrl_if bus ();

    sha256_block_ctrl #(.CORE(4'd3), .WAIT_MAX(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .stream     (bus),
        .core_en    (core_en),
        .core_rcntr (core_rcntr),
        .core_kt    (core_kt),
        .core_mt    (core_mt),
        .core_iv    (core_iv),
        .core_wreg  (core_wreg),
        .core_valid (core_valid),
        .core_id    (core_id),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural round core driven by the sequencer outputs
    int    core_lat  = 0;
    bit    core_mute = 1'b0;
    int    seq_bad   = 0;
    bit    running, pend, fired;
    int    rnd_m, dly;
    hash_t st;
    word_t w_m [0:63];

    function automatic word_t rotr(word_t x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t wt_of(int r);
        word_t s0, s1;
        if (r < 16) return core_mt;
        s0 = rotr(w_m[r-15], 7) ^ rotr(w_m[r-15], 18) ^ (w_m[r-15] >> 3);
        s1 = rotr(w_m[r-2], 17) ^ rotr(w_m[r-2], 19) ^ (w_m[r-2] >> 10);
        return s1 + w_m[r-7] + s0 + w_m[r-16];
    endfunction

    function automatic hash_t do_round(hash_t s, word_t k, word_t w);
        word_t t1, t2;
        hash_t n;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        n = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            running    <= 1'b0;
            pend       <= 1'b0;
            fired      <= 1'b0;
            core_valid <= 1'b0;
            core_wreg  <= '0;
        end else begin
            core_valid <= 1'b0;
            if (!core_en) begin
                running <= 1'b0;
                pend    <= 1'b0;
                fired   <= 1'b0;
            end else if (!running && !pend) begin
                if (core_rcntr != 6'd0) seq_bad <= seq_bad + 1;
                w_m[0]  <= core_mt;
                st      <= do_round(core_iv, core_kt, core_mt);
                rnd_m   <= 1;
                running <= 1'b1;
            end else if (running) begin
                if (int'(core_rcntr) != rnd_m) seq_bad <= seq_bad + 1;
                w_m[rnd_m] <= wt_of(rnd_m);
                st         <= do_round(st, core_kt, wt_of(rnd_m));
                rnd_m      <= rnd_m + 1;
                if (rnd_m == 63) begin
                    running <= 1'b0;
                    pend    <= 1'b1;
                    dly     <= core_lat;
                end
            end else begin
                if (core_rcntr != 6'd63) seq_bad <= seq_bad + 1;
                if (!fired && !core_mute) begin
                    if (dly == 0) begin
                        core_valid <= 1'b1;
                        core_wreg  <= st;
                        fired      <= 1'b1;
                    end else begin
                        dly <= dly - 1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_msg_ready"}, bus.msg_ready, 1'b0);
        check({tag, "_core_en"}, core_en, 1'b0);
        check({tag, "_rcntr"}, core_rcntr, 6'd0);
        check({tag, "_kt"}, core_kt, 32'h0);
        check({tag, "_mt"}, core_mt, 32'h0);
        check({tag, "_iv"}, core_iv, H0_EXP);
        check({tag, "_dig_valid"}, bus.dig_valid, 1'b0);
        check({tag, "_dig_data"}, bus.dig_data, H0_EXP);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // Returns at the negedge of the first RUN cycle
    task automatic send_block(input string tag, input word_t w [16], input logic last, input bit rnd_valid);
        int  idx   = 0;
        int  guard = 0;
        bit  hs;
        while (idx < 16 && guard < 2000) begin
            @(negedge clk);
            bus.msg_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.msg_data  = w[idx];
            bus.msg_last  = (idx == 15) ? last : ~last;
            hs = bus.msg_valid && bus.msg_ready;
            @(posedge clk);
            if (hs) idx++;
            guard++;
        end
        @(negedge clk);
        bus.msg_valid = 1'b0;
        if (idx < 16) check({tag, "_send_timeout"}, idx, 16);
    endtask

    task automatic wait_digest(input string tag, input logic [255:0] exp, input int hold);
        int n = 0;
        int stall_bad = 0;
        int unstable = 0;
        logic [255:0] first;
        @(negedge clk);
        while (!bus.dig_valid && n < 400) begin
            if (bus.msg_ready) stall_bad++;
            @(negedge clk);
            n++;
        end
        check({tag, "_dig_valid"}, bus.dig_valid, 1'b1);
        check({tag, "_stall"}, stall_bad, 0);
        check({tag, "_latency"}, n, 66 + core_lat);
        check({tag, "_digest"}, bus.dig_data, exp);
        first = bus.dig_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.dig_valid || bus.dig_data !== first || bus.msg_ready) unstable++;
        end
        if (hold > 0) check({tag, "_hold"}, unstable, 0);
        bus.dig_ready = 1'b1;
        @(negedge clk);
        bus.dig_ready = 1'b0;
        check({tag, "_b2b_ready"}, bus.msg_ready, 1'b1);
        check({tag, "_dig_drop"}, bus.dig_valid, 1'b0);
        check({tag, "_h_reinit"}, core_iv, H0_EXP);
        check({tag, "_rcntr_seq"}, seq_bad, 0);
    endtask

    word_t blk_abc [16];
    word_t blk_empty [16];
    word_t blk_two1 [16];
    word_t blk_two2 [16];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        blk_abc = '{default: 32'h0};
        blk_abc[0] = 32'h61626380;
        blk_abc[15] = 32'h00000018;
        blk_empty = '{default: 32'h0};
        blk_empty[0] = 32'h80000000;
        blk_two1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two2 = '{default: 32'h0};
        blk_two2[15] = 32'h000001c0;

        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.msg_last  = 1'b0;
        bus.dig_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        check("core_id", core_id, 4'd3);
        rst = 1'b1;

        // "abc", ready consumer, round 0 directly after the last word
        core_lat = 0;
        send_block("abc", blk_abc, 1'b1, 1'b0);
        check("abc_r0", {core_en, core_rcntr, core_kt}, {1'b1, 6'd0, 32'h428a2f98});
        wait_digest("abc", DIG_ABC, 0);

        core_lat = 5;
        send_block("empty", blk_empty, 1'b1, 1'b0);
        wait_digest("empty", DIG_EMPTY, 0);

        core_lat = 3;
        send_block("two_b1", blk_two1, 1'b0, 1'b0);
        send_block("two_b2", blk_two2, 1'b1, 1'b0);
        wait_digest("two", DIG_TWO, 0);

        core_lat = 13;
        send_block("rand", blk_abc, 1'b1, 1'b1);
        wait_digest("rand", DIG_ABC, 20);

        // Core never answers: timeout after WAIT_MAX cycles
        core_mute = 1'b1;
        core_lat  = 0;
        send_block("to", blk_abc, 1'b1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("to_err", err, 1'b1);
        check("to_cycles", n, 79);
        check("to_idle", {busy, bus.msg_ready, bus.dig_valid}, 3'b000);
        check("to_h0", core_iv, H0_EXP);
        @(negedge clk);
        check("to_load", bus.msg_ready, 1'b1);
        core_mute = 1'b0;
        send_block("to_abc", blk_abc, 1'b1, 1'b0);
        wait_digest("to_abc", DIG_ABC, 0);
        check("to_err_sticky", err, 1'b1);

        // Reset in the middle of RUN
        send_block("mid", blk_abc, 1'b1, 1'b0);
        n = 0;
        while (!(core_en && core_rcntr == 6'd30) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_r30", core_rcntr, 6'd30);
        rst = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b1;
        send_block("post", blk_abc, 1'b1, 1'b0);
        wait_digest("post", DIG_ABC, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
